// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline front end.
// Opcode/PC constants, fetch FSM states and the IF/ID bundle.
package cpu_pkg;

    localparam logic [3:0]  OPC_HLT = 4'hF;
    localparam logic [15:0] PC_INC  = 16'd2;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] curr_pc;
        logic [15:0] next_pc;
        logic [15:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold, or flush to a bubble.
// Flush takes priority over load; neither asserted means hold.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, skid buffer, redirect/HLT FSM.
// Define FETCH_PERF_EN to add perf_fetched/perf_bubbles counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] curr_pc_fd,
    output logic [15:0] next_pc_fd,
    output logic [15:0] curr_instr_fd,
    output logic        valid_fd,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_bubbles
`endif
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  tgt;
    logic         buf_valid;
    logic [15:0]  buf_pc;
    logic [15:0]  buf_instr;

    logic         accept;
    logic         release_buf;
    logic         ld;
    logic         fl;
    logic [15:0]  tgt_in;
    logic [15:0]  src_pc;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    always_comb begin
        imem_req = 1'b0;
        unique case (state)
            RUN:     imem_req = !buf_valid;
            DRAIN:   imem_req = 1'b1;
            HALT:    imem_req = 1'b0;
            default: imem_req = 1'b0;
        endcase
    end

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign tgt_in    = redirect_pc & 16'hFFFE;

    assign accept      = (state == RUN) && imem_req
                         && imem_ready && !redirect;
    assign release_buf = !redirect && !stall_in && buf_valid;

    // Accept and release are exclusive, so buf_valid picks the source.
    assign src_pc         = buf_valid ? buf_pc : pc;
    assign ifid_d.curr_pc = src_pc;
    assign ifid_d.next_pc = src_pc + PC_INC;
    assign ifid_d.instr   = buf_valid ? buf_instr : imem_rdata;
    assign ifid_d.valid   = 1'b1;

    assign ld = (accept && !stall_in) || release_buf;
    assign fl = redirect
                || (!stall_in && !buf_valid && !accept);

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .flush (fl),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign curr_pc_fd    = ifid_q.curr_pc;
    assign next_pc_fd    = ifid_q.next_pc;
    assign curr_instr_fd = ifid_q.instr;
    assign valid_fd      = ifid_q.valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            tgt       <= RESET_PC;
            buf_valid <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else if (redirect) begin
            buf_valid <= 1'b0;
            // An outstanding miss must finish before the target goes out.
            if (imem_req && !imem_ready) begin
                tgt   <= tgt_in;
                state <= DRAIN;
            end else begin
                pc    <= tgt_in;
                state <= RUN;
            end
        end else if (state == DRAIN) begin
            if (imem_ready) begin
                pc    <= tgt;
                state <= RUN;
            end
        end else if (accept) begin
            if (imem_rdata[15:12] == OPC_HLT) begin
                state <= HALT;
            end else begin
                pc <= pc + PC_INC;
            end
            if (stall_in) begin
                buf_valid <= 1'b1;
                buf_pc    <= pc;
                buf_instr <= imem_rdata;
            end
        end else if (release_buf) begin
            buf_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (ld && !fl && perf_fetched != 16'hFFFF) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            if (!valid_fd && state != HALT
                && perf_bubbles != 16'hFFFF) begin
                perf_bubbles <= perf_bubbles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a behavioural model.
// Builds with or without FETCH_PERF_EN.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;
    logic [15:0] curr_pc_fd;
    logic [15:0] next_pc_fd;
    logic [15:0] curr_instr_fd;
    logic        valid_fd;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_bubbles;
`endif

    fetch_stage #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .curr_pc_fd    (curr_pc_fd),
        .next_pc_fd    (next_pc_fd),
        .curr_instr_fd (curr_instr_fd),
        .valid_fd      (valid_fd),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural view: where fetch is, what decode sees, what is parked.
    logic [15:0] m_pc;
    logic [15:0] m_target;
    bit          m_drain;
    bit          m_halt;
    logic [31:0] m_skid[$];
    logic [15:0] e_cpc, e_npc, e_ins;
    logic        e_val;
    int          m_fetched, m_bubbles;

    function automatic logic m_req();
        return m_drain || (!m_halt && m_skid.size() == 0);
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 16'h0000;
        m_target = 16'h0000;
        m_drain = 0;
        m_halt = 0;
        m_skid.delete();
        {e_cpc, e_npc, e_ins, e_val} = '0;
        m_fetched = 0;
        m_bubbles = 0;
    endtask

    task automatic show(logic [15:0] p, logic [15:0] w);
        e_cpc = p;
        e_npc = p + 16'd2;
        e_ins = w;
        e_val = 1'b1;
        if (m_fetched < 16'hFFFF) m_fetched++;
    endtask

    task automatic m_step(bit st, bit rd, logic [15:0] rpc,
                          bit rdy, logic [15:0] data);
        bit req;
        logic [31:0] e;
        req = m_req();
        if (!e_val && !m_halt && m_bubbles < 16'hFFFF) m_bubbles++;
        if (rd) begin
            {e_cpc, e_npc, e_ins, e_val} = '0;
            m_skid.delete();
            m_halt = 0;
            if (req && !rdy) begin
                m_drain = 1;
                m_target = {rpc[15:1], 1'b0};
            end else begin
                m_drain = 0;
                m_pc = {rpc[15:1], 1'b0};
            end
        end else begin
            if (!m_drain && !m_halt && req && rdy) begin
                if (st) m_skid.push_back({m_pc, data});
                else show(m_pc, data);
                if (data[15:12] == 4'hF) m_halt = 1;
                else m_pc = m_pc + 16'd2;
            end else if (!st && m_skid.size() != 0) begin
                e = m_skid.pop_front();
                show(e[31:16], e[15:0]);
            end else if (!st) begin
                {e_cpc, e_npc, e_ins, e_val} = '0;
            end
            if (m_drain && rdy) begin
                m_drain = 0;
                m_pc = m_target;
            end
        end
    endtask

    task automatic cmp_all();
        chk("imem_req", {15'd0, imem_req}, {15'd0, m_req()});
        chk("imem_addr", imem_addr, m_pc);
        chk("curr_pc_fd", curr_pc_fd, e_cpc);
        chk("next_pc_fd", next_pc_fd, e_npc);
        chk("curr_instr_fd", curr_instr_fd, e_ins);
        chk("valid_fd", {15'd0, valid_fd}, {15'd0, e_val});
        chk("halted", {15'd0, halted}, {15'd0, m_halt});
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 16'(m_fetched));
        chk("perf_bubbles", perf_bubbles, 16'(m_bubbles));
`endif
    endtask

    task automatic tick(bit st, bit rd, logic [15:0] rpc,
                        bit rdy, logic [15:0] data);
        stall_in = st;
        redirect = rd;
        redirect_pc = rpc;
        imem_ready = rdy;
        imem_rdata = data;
        m_step(st, rd, rpc, rdy, data);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp_all();
        chk("rst valid_fd", {15'd0, valid_fd}, 16'd0);
        rst = 1'b0;
        #1;
        chk("first req", {15'd0, imem_req}, 16'd1);
        chk("first addr", imem_addr, 16'h0000);

        tick(0, 0, 0, 1, 16'h1234);
        chk("t1 pc", curr_pc_fd, 16'h0000);
        chk("t1 npc", next_pc_fd, 16'h0002);
        chk("t1 ins", curr_instr_fd, 16'h1234);
        chk("t1 addr", imem_addr, 16'h0002);
        tick(0, 0, 0, 1, 16'h5678);
        chk("t2 ins", curr_instr_fd, 16'h5678);
        chk("t2 addr", imem_addr, 16'h0004);

        tick(1, 0, 0, 1, 16'hA001);
        chk("stall hold", curr_instr_fd, 16'h5678);
        chk("stall req", {15'd0, imem_req}, 16'd0);
        tick(1, 0, 0, 0, 16'h0000);
        tick(1, 0, 0, 0, 16'h0000);
        chk("stall hold3", curr_pc_fd, 16'h0002);
        tick(0, 0, 0, 0, 16'h0000);
        chk("release pc", curr_pc_fd, 16'h0004);
        chk("release ins", curr_instr_fd, 16'hA001);
        chk("release addr", imem_addr, 16'h0006);

        tick(0, 0, 0, 1, 16'h1111);
        tick(1, 1, 16'h0040, 0, 16'h0000);
        chk("flush valid", {15'd0, valid_fd}, 16'd0);
        chk("drain addr", imem_addr, 16'h0008);
        tick(0, 0, 0, 0, 16'h0000);
        chk("drain addr2", imem_addr, 16'h0008);
        tick(0, 0, 0, 1, 16'hBEEF);
        chk("discard", curr_instr_fd, 16'h0000);
        chk("tgt addr", imem_addr, 16'h0040);

        tick(0, 1, 16'h000C, 1, 16'h2222);
        tick(0, 0, 0, 1, 16'hF000);
        chk("hlt ins", curr_instr_fd, 16'hF000);
        chk("hlt pc", curr_pc_fd, 16'h000C);
        chk("halted", {15'd0, halted}, 16'd1);
        tick(0, 0, 0, 1, 16'h3333);
        chk("halt req", {15'd0, imem_req}, 16'd0);
        tick(0, 1, 16'h0020, 0, 16'h0000);
        chk("unhalt", {15'd0, halted}, 16'd0);
        chk("resume addr", imem_addr, 16'h0020);

        tick(0, 1, 16'hFFFF, 1, 16'h0000);
        chk("wrap addr", imem_addr, 16'hFFFE);
        tick(0, 0, 0, 1, 16'h0102);
        chk("wrap npc", next_pc_fd, 16'h0000);
        chk("wrap next", imem_addr, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0),
                 16'($urandom),
                 ($urandom_range(0, 1) == 1),
                 16'($urandom));
        end

        tick(0, 1, 16'h0100, 1, 16'h0000);
        imem_ready = 1'b0;
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst valid", {15'd0, valid_fd}, 16'd0);
        chk("arst pc", curr_pc_fd, 16'h0000);
        chk("arst ins", curr_instr_fd, 16'h0000);
        chk("arst addr", imem_addr, 16'h0000);
        chk("arst halted", {15'd0, halted}, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        cmp_all();
        tick(0, 0, 0, 1, 16'h4321);
        chk("post rst ins", curr_instr_fd, 16'h4321);
        chk("post rst addr", imem_addr, 16'h0002);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined 16-bit processor, directly upstream of the decode stage. It owns the PC register, issues requests to the instruction memory port over a ready-based handshake, and drives the IF/ID pipeline register (`curr_pc_fd`, `next_pc_fd`, `curr_instr_fd`) consumed by decode. It also:
- buffers a fetched word while decode stalls;
- applies branch redirects and flushes from decode;
- stops fetching on HLT.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall_in`  in  1  hazard stall from decode; hold IF/ID contents
- `redirect`  in  1  taken branch/jump resolved in decode
- `redirect_pc`  in  16  branch target; bit 0 forced to 0 internally
- `imem_req`  out  1  instruction memory request
- `imem_addr`  out  16  request address (the PC)
- `imem_rdata`  in  16  instruction word, valid when `imem_ready`=1
- `imem_ready`  in  1  request completes this cycle
- `curr_pc_fd`  out  16  IF/ID: PC of the held instruction
- `next_pc_fd`  out  16  IF/ID: `curr_pc_fd`+2, modulo 2^16
- `curr_instr_fd`  out  16  IF/ID: instruction word
- `valid_fd`  out  1  IF/ID holds a real instruction (0 = bubble)
- `halted`  out  1  fetch is parked on HLT

## Operation
**Memory contract**
- While `imem_req`=1, `imem_addr` is stable until a cycle with `imem_ready`=1.
- `imem_req` never drops mid-transaction.

**State machine** (states RUN, DRAIN, HALT; reset → RUN)
- RUN
  - Outputs: `imem_req` = !`buf_valid`; `imem_addr` = `pc`.
  - A word is *accepted* on `imem_req && imem_ready && !redirect`.
  - On accept: if opcode [15:12] = 4'hF, `pc` holds and the state goes to HALT; otherwise `pc` ← `pc`+2.
  - Accepted word with `stall_in`=0: load IF/ID with `{pc, pc+2, word}`, `valid_fd`=1.
  - Accepted word with `stall_in`=1: write `{pc, word}` to the one-entry skid buffer and set `buf_valid`.
- Stall release (`stall_in`=0 with `buf_valid`=1): IF/ID ← buffer, `buf_valid` cleared. No request is issued that cycle.
- `stall_in`=1 without an accept: IF/ID holds.
- `stall_in`=0 with no accept and no buffered word: IF/ID is loaded with a bubble (`valid_fd`=0, fields zeroed).
- `redirect`=1 (priority over `stall_in`) in any state:
  - IF/ID is flushed (`valid_fd`=0, all fields 0); `buf_valid` is cleared.
  - If a request is pending and `imem_ready`=0: store the target in `tgt`, go to DRAIN.
  - Otherwise: `pc` ← `redirect_pc`, go to RUN. A completing word that cycle is discarded.
- DRAIN
  - Keeps `imem_req`=1 at the stale address.
  - On `imem_ready`: discard the data, `pc` ← `tgt`, go to RUN.
  - A further `redirect` in DRAIN overwrites `tgt`.
- HALT
  - `imem_req`=0, `halted`=1; IF/ID behaves as in RUN with no accepts.
  - A `redirect` cancels the speculative halt as described above.

**Widths**
- All PC arithmetic is 16-bit and wraps: 16'hFFFE + 2 = 16'h0000.

## Timing
- Reset values: `pc`=`RESET_PC`, state RUN, `buf_valid`=0, all IF/ID outputs 0, `halted`=0.
- `imem_req`=1 in the first cycle after reset deassertion.
- Latency: `imem_ready` in cycle N → IF/ID visible in cycle N+1 (without a stall).
- Throughput with a zero-wait memory is one instruction per cycle.
- Redirect penalty:
  - Target request issues the cycle after `redirect`.
  - With a pending miss, the target request issues the cycle after the stale `imem_ready`.
- Reset asserted mid-transaction: everything returns to reset values immediately; the memory must tolerate a dropped request on reset only.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetched` (16; count of IF/ID loads with `valid_fd`=1) and `perf_bubbles` (16; cycles with `valid_fd`=0 outside HALT).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared `cpu_pkg` holds:
  - `OPC_HLT` = 4'hF;
  - `PC_INC` = 16'd2;
  - the `fetch_state_t` enum {RUN, DRAIN, HALT}.
- One sub-module, `if_id_reg`: the IF/ID register with load, hold, and flush-to-bubble controls (flush has priority). The FSM, PC, and skid buffer stay in `fetch_stage`.

## Test plan
- Reset, zero-wait memory returning 16'h1234, 16'h5678 → `imem_addr` 0, 2; IF/ID {0, 2, 1234}, then {2, 4, 5678}; `valid_fd`=1.
- `stall_in` held 3 cycles while word 16'hA001 at PC 4 completes → IF/ID unchanged during the stall; `imem_req` low after the accept; {4, 6, A001} appears the cycle after release; next request is address 6.
- `redirect`=1, target 16'h0040, at the same time as `stall_in` and a pending miss at PC 8 → IF/ID flushed; `imem_addr` stays 8 until ready; data discarded; next request is 16'h0040.
- Fetch 16'hF000 at PC 16'h000C → IF/ID holds HLT; `halted`=1; `imem_req`=0 thereafter. A later redirect to 16'h0020 → `halted`=0, fetch resumes at 16'h0020.
- `redirect_pc` = 16'hFFFF, then sequential fetch → `imem_addr` 16'hFFFE; `next_pc_fd`=16'h0000; next request is 0.
- Assert `rst` during a pending miss → all outputs are reset values within the same cycle; first request after release is `RESET_PC`.
